sdram_inport_arbiter: RTL and testbench
=======================================

SDRAM_INPORT_ARBITER -- requirements
Module: sdram_inport_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255; the maximum number of cycles in WAIT_ACK before the block aborts the transaction.
REQ-002 clk_i  in  1  single clock; all logic samples on the rising edge.
REQ-003 rst_ni  in  1  synchronous reset, active-low.
REQ-004 req_wr_i  in  2x4  per-requester byte write mask; a non-zero value requests a write.
REQ-005 req_rd_i  in  2x1  per-requester read request.
REQ-006 req_addr_i  in  2x32  per-requester byte address.
REQ-007 req_wdata_i  in  2x32  per-requester write data.
REQ-008 req_accept_o  out  2x1  one-cycle pulse: the command has been accepted by the core.
REQ-009 req_ack_o  out  2x1  one-cycle pulse: the transaction has completed.
REQ-010 req_error_o  out  2x1  error qualifier, valid with req_ack_o.
REQ-011 req_rdata_o  out  32  read data, valid with req_ack_o.
REQ-012 core_wr_o / core_rd_o / core_addr_o / core_wdata_o  out  4/1/32/32  command to the sdram_axi_core inport.
REQ-013 core_accept_i / core_ack_i / core_error_i / core_rdata_i  in  1/1/1/32  response from the sdram_axi_core inport.
REQ-014 busy_o  out  1  high in any state other than IDLE.

Function
REQ-015 Pending request: requester i is pending when req_wr_i[i]!=0 or req_rd_i[i]=1.
- A requester holds its command stable until it receives req_accept_o.
REQ-016 Write precedence: if both req_wr_i[i]!=0 and req_rd_i[i]=1, the command is treated as a write and the read is ignored.
REQ-017 States are IDLE, ISSUE and WAIT_ACK. Only one transaction is outstanding at a time.
REQ-018 IDLE: if any request is pending, select grant g as follows:
- Round-robin: the requester not equal to last_grant wins if it is pending; otherwise the other pending requester wins.
- Capture that requester's mask, rd, addr and wdata into the core_* registers.
- Go to ISSUE.
- Latency: request seen at edge n, core_* valid from cycle n+1.
REQ-019 ISSUE: core_* stay stable. On core_accept_i=1:
- Combinationally assert req_accept_o[g] in that same cycle.
- Clear core_wr_o and core_rd_o at the next edge.
- Clear the timeout counter.
- Go to WAIT_ACK.
REQ-020 WAIT_ACK: on core_ack_i=1, in that same cycle:
- Combinationally drive req_ack_o[g]=1, req_error_o[g]=core_error_i and req_rdata_o=core_rdata_i.
- At the next edge, set last_grant=g and go to IDLE.
REQ-021 Timeout counter: an 8-bit (or wider) counter increments each WAIT_ACK cycle without ack. When it equals TIMEOUT_CYCLES:
- Pulse req_ack_o[g] and req_error_o[g] for one cycle, with req_rdata_o=0.
- Set last_grant=g and go to IDLE.
REQ-022 Ack outside WAIT_ACK: core_ack_i in IDLE or ISSUE (e.g. a late ack after a timeout) is ignored, and no req_ack_o is produced.
REQ-023 Non-granted requester: it never sees accept, ack or error pulses. req_rdata_o is 0 whenever no req_ack_o is high.
REQ-024 Requester withdrawal: if the granted requester drops its request while in ISSUE, the captured command is still issued to completion.
REQ-025 Back-to-back: a new grant may be taken in the IDLE cycle immediately after completion.
- Minimum spacing between core commands is 1 idle cycle.
REQ-026 Simultaneous first requests: when both requesters are pending out of reset, requester 0 wins.

Reset
REQ-027 When rst_ni=0 at a rising edge:
- State goes to IDLE.
- last_grant goes to 1.
- The timeout counter goes to 0.
- core_wr_o=0, core_rd_o=0, core_addr_o=0 and core_wdata_o=0.
REQ-028 During reset, all req_accept_o, req_ack_o, req_error_o and req_rdata_o are 0.
REQ-029 Reset mid-transaction abandons the transaction silently, with no ack or error to any requester. Any later core_ack_i is ignored per REQ-022.

Verification
REQ-030 Single write: requester 0 drives wr=4'hF, addr=0x4, wdata=0xDEADBEEF; core accepts 3 cycles later -> core_* match in ISSUE, req_accept_o[0] pulses once, and req_ack_o[0] pulses once on core_ack_i.
REQ-031 Read data routing: requester 1 reads addr 0x8; core acks with rdata=0x12345678 and error=0 -> req_rdata_o=0x12345678 with req_ack_o[1] only.
REQ-032 Round-robin: both requesters hold continuous requests for 4 transactions -> grant order is 0,1,0,1, with no starvation.
REQ-033 Timeout: core never acks after accept -> exactly TIMEOUT_CYCLES cycles after entering WAIT_ACK, req_ack_o and req_error_o pulse together with rdata=0. A later stray core_ack_i produces no output.
REQ-034 Write precedence: a requester drives wr=4'h3 and rd=1 together -> core_wr_o=4'h3 and core_rd_o=0.
REQ-035 Reset mid-operation: rst_ni is low for 1 cycle during WAIT_ACK -> all outputs are 0, busy_o=0, and the next request with both pending is granted to requester 0.

Source files
------------

// File: rtl/sdram_inport_arbiter.sv
// Two-requester round-robin arbiter in front of the sdram_axi_core inport.
// One transaction outstanding at a time, with a WAIT_ACK timeout that aborts with an error.
module sdram_inport_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0][3:0]  req_wr_i,
  input  logic [1:0]       req_rd_i,
  input  logic [1:0][31:0] req_addr_i,
  input  logic [1:0][31:0] req_wdata_i,
  output logic [1:0]       req_accept_o,
  output logic [1:0]       req_ack_o,
  output logic [1:0]       req_error_o,
  output logic [31:0]      req_rdata_o,
  output logic [3:0]       core_wr_o,
  output logic             core_rd_o,
  output logic [31:0]      core_addr_o,
  output logic [31:0]      core_wdata_o,
  input  logic             core_accept_i,
  input  logic             core_ack_i,
  input  logic             core_error_i,
  input  logic [31:0]      core_rdata_i,
  output logic             busy_o
);

  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q;
  logic              grant_q;
  logic              sel_grant;
  logic [1:0]        pending;
  logic [CNT_W-1:0]  tmo_q;
  logic              timeout_hit;

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      pending[i] = (|req_wr_i[i]) | req_rd_i[i];
    end
    // Prefer the requester that was not served last.
    if (pending[~last_grant_q]) sel_grant = ~last_grant_q;
    else                        sel_grant = last_grant_q;
    timeout_hit = (state_q == WAIT_ACK) && (tmo_q == CNT_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (|pending) state_d = ISSUE;
      ISSUE:    if (core_accept_i) state_d = WAIT_ACK;
      WAIT_ACK: if (core_ack_i || timeout_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are gated by rst_ni so nothing leaks while reset is asserted mid-transaction.
  always_comb begin
    req_accept_o = '0;
    req_ack_o    = '0;
    req_error_o  = '0;
    req_rdata_o  = '0;
    busy_o       = (state_q != IDLE);
    if (rst_ni) begin
      case (state_q)
        ISSUE: begin
          if (core_accept_i) req_accept_o[grant_q] = 1'b1;
        end
        WAIT_ACK: begin
          if (core_ack_i) begin
            req_ack_o[grant_q]   = 1'b1;
            req_error_o[grant_q] = core_error_i;
            req_rdata_o          = core_rdata_i;
          end else if (timeout_hit) begin
            req_ack_o[grant_q]   = 1'b1;
            req_error_o[grant_q] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      tmo_q        <= '0;
      core_wr_o    <= '0;
      core_rd_o    <= 1'b0;
      core_addr_o  <= '0;
      core_wdata_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending) begin
            grant_q      <= sel_grant;
            core_wr_o    <= req_wr_i[sel_grant];
            core_rd_o    <= req_rd_i[sel_grant] & ~(|req_wr_i[sel_grant]);
            core_addr_o  <= req_addr_i[sel_grant];
            core_wdata_o <= req_wdata_i[sel_grant];
          end
        end
        ISSUE: begin
          if (core_accept_i) begin
            core_wr_o <= '0;
            core_rd_o <= 1'b0;
            tmo_q     <= '0;
          end
        end
        WAIT_ACK: begin
          if (core_ack_i || timeout_hit) last_grant_q <= grant_q;
          else                           tmo_q        <= tmo_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_inport_arbiter.sv
// Scoreboard bench for sdram_inport_arbiter: expected core commands are queued
// when requests are driven and compared as the arbiter issues them.
module tb_sdram_inport_arbiter;

  localparam int unsigned TMO = 10;

  logic             clk;
  logic             rst_ni;
  logic [1:0][3:0]  req_wr;
  logic [1:0]       req_rd;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       req_accept_o, req_ack_o, req_error_o;
  logic [31:0]      req_rdata_o;
  logic [3:0]       core_wr_o;
  logic             core_rd_o;
  logic [31:0]      core_addr_o, core_wdata_o;
  logic             core_accept_i, core_ack_i, core_error_i;
  logic [31:0]      core_rdata_i;
  logic             busy_o;

  typedef struct {
    int          id;
    logic [3:0]  wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  sdram_inport_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_wr_i     (req_wr),
    .req_rd_i     (req_rd),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_accept_o (req_accept_o),
    .req_ack_o    (req_ack_o),
    .req_error_o  (req_error_o),
    .req_rdata_o  (req_rdata_o),
    .core_wr_o    (core_wr_o),
    .core_rd_o    (core_rd_o),
    .core_addr_o  (core_addr_o),
    .core_wdata_o (core_wdata_o),
    .core_accept_i(core_accept_i),
    .core_ack_i   (core_ack_i),
    .core_error_i (core_error_i),
    .core_rdata_i (core_rdata_i),
    .busy_o       (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic set_req(input int id, input logic [3:0] wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_wr[id]    = wr;
    req_rd[id]    = rd;
    req_addr[id]  = addr;
    req_wdata[id] = wdata;
  endtask

  task automatic push_exp(input int id, input logic [3:0] wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.id = id; e.wr = wr; e.rd = rd; e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for the arbiter to leave IDLE, then checks the issued command.
  task automatic wait_issue(output exp_t e, output bit ok);
    bit seen;
    ok = 1'b0;
    e.id = 0; e.wr = '0; e.rd = 1'b0; e.addr = '0; e.wdata = '0;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got 0 entries, required >= 1");
      return;
    end
    e = exp_q.pop_front();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk); #1;
      if (busy_o === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL grant_wait: busy_o got %b, required 1 within 20 cycles", busy_o);
      return;
    end
    vectors++;
    if ({core_wr_o, core_rd_o, core_addr_o, core_wdata_o} !== {e.wr, e.rd, e.addr, e.wdata}) begin
      miscompares++;
      $display("FAIL issue_cmd: got wr=%h rd=%b addr=%h wdata=%h, required wr=%h rd=%b addr=%h wdata=%h",
               core_wr_o, core_rd_o, core_addr_o, core_wdata_o, e.wr, e.rd, e.addr, e.wdata);
    end
    vectors++;
    if (req_accept_o !== 2'b00) begin
      miscompares++;
      $display("FAIL early_accept: got %b, required 00", req_accept_o);
    end
    ok = 1'b1;
  endtask

  task automatic accept_cycle(input exp_t e, input bit drop);
    logic [1:0] onehot;
    onehot = 2'b00;
    onehot[e.id] = 1'b1;
    @(negedge clk); core_accept_i = 1'b1; #1;
    vectors++;
    if (req_accept_o !== onehot) begin
      miscompares++;
      $display("FAIL accept_pulse: got %b, required %b", req_accept_o, onehot);
    end
    @(negedge clk); core_accept_i = 1'b0;
    if (drop) set_req(e.id, 4'h0, 1'b0, 32'h0, 32'h0);
    #1;
    vectors++;
    if ({req_accept_o, core_wr_o, core_rd_o, busy_o} !== {2'b00, 4'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL post_accept: got acc=%b wr=%h rd=%b busy=%b, required acc=00 wr=0 rd=0 busy=1",
               req_accept_o, core_wr_o, core_rd_o, busy_o);
    end
  endtask

  task automatic serve(input int acc_delay, input logic [31:0] rdata, input logic err, input bit drop);
    exp_t e;
    bit ok;
    logic [1:0] onehot, exp_err;
    wait_issue(e, ok);
    if (!ok) return;
    repeat (acc_delay) @(negedge clk);
    #1;
    vectors++;
    if ({core_wr_o, core_rd_o, core_addr_o, core_wdata_o} !== {e.wr, e.rd, e.addr, e.wdata}) begin
      miscompares++;
      $display("FAIL cmd_stable: got wr=%h rd=%b addr=%h, required wr=%h rd=%b addr=%h",
               core_wr_o, core_rd_o, core_addr_o, e.wr, e.rd, e.addr);
    end
    accept_cycle(e, drop);
    onehot = 2'b00;
    onehot[e.id] = 1'b1;
    exp_err = err ? onehot : 2'b00;
    @(negedge clk); core_ack_i = 1'b1; core_rdata_i = rdata; core_error_i = err; #1;
    vectors++;
    if ({req_ack_o, req_error_o, req_rdata_o} !== {onehot, exp_err, rdata}) begin
      miscompares++;
      $display("FAIL ack_route: got ack=%b err=%b rdata=%h, required ack=%b err=%b rdata=%h",
               req_ack_o, req_error_o, req_rdata_o, onehot, exp_err, rdata);
    end
    @(negedge clk); core_ack_i = 1'b0; core_error_i = 1'b0; core_rdata_i = 32'hA5A5_5A5A; #1;
    vectors++;
    if ({req_ack_o, req_rdata_o, busy_o} !== {2'b00, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL post_ack: got ack=%b rdata=%h busy=%b, required ack=00 rdata=0 busy=0",
               req_ack_o, req_rdata_o, busy_o);
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    set_req(0, 4'hF, 1'b1, 32'h10, 32'h1);
    set_req(1, 4'h0, 1'b1, 32'h20, 32'h2);
    core_accept_i = 1'b1; core_ack_i = 1'b1; core_error_i = 1'b1;
    core_rdata_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({req_accept_o, req_ack_o, req_error_o, req_rdata_o, busy_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_req_out: got acc=%b ack=%b err=%b rdata=%h busy=%b, required all 0",
               req_accept_o, req_ack_o, req_error_o, req_rdata_o, busy_o);
    end
    vectors++;
    if ({core_wr_o, core_rd_o, core_addr_o, core_wdata_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_core_out: got wr=%h rd=%b addr=%h wdata=%h, required all 0",
               core_wr_o, core_rd_o, core_addr_o, core_wdata_o);
    end
    set_req(0, 4'h0, 1'b0, 32'h0, 32'h0);
    set_req(1, 4'h0, 1'b0, 32'h0, 32'h0);
    core_accept_i = 1'b0; core_ack_i = 1'b0; core_error_i = 1'b0;
    core_rdata_i = 32'hA5A5_5A5A;
    @(negedge clk); rst_ni = 1'b1;
  endtask

  task automatic test_round_robin;
    set_req(0, 4'hF, 1'b0, 32'h100, 32'hAAAA_0000);
    set_req(1, 4'h0, 1'b1, 32'h200, 32'h0);
    push_exp(0, 4'hF, 1'b0, 32'h100, 32'hAAAA_0000);
    push_exp(1, 4'h0, 1'b1, 32'h200, 32'h0);
    push_exp(0, 4'hF, 1'b0, 32'h100, 32'hAAAA_0000);
    push_exp(1, 4'h0, 1'b1, 32'h200, 32'h0);
    for (int t = 0; t < 4; t++) serve(0, 32'h1000 + t, 1'b0, 1'b0);
    set_req(0, 4'h0, 1'b0, 32'h0, 32'h0);
    set_req(1, 4'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_single_write;
    @(negedge clk);
    set_req(0, 4'hF, 1'b0, 32'h4, 32'hDEAD_BEEF);
    push_exp(0, 4'hF, 1'b0, 32'h4, 32'hDEAD_BEEF);
    serve(3, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_read_routing;
    @(negedge clk);
    set_req(1, 4'h0, 1'b1, 32'h8, 32'h0);
    push_exp(1, 4'h0, 1'b1, 32'h8, 32'h0);
    serve(1, 32'h1234_5678, 1'b0, 1'b1);
  endtask

  task automatic test_write_precedence;
    @(negedge clk);
    set_req(0, 4'h3, 1'b1, 32'hC, 32'h0BAD_F00D);
    push_exp(0, 4'h3, 1'b0, 32'hC, 32'h0BAD_F00D);
    serve(0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_timeout;
    exp_t e;
    bit ok;
    logic [1:0] exp_v;
    @(negedge clk);
    set_req(1, 4'h1, 1'b0, 32'h40, 32'h1111_2222);
    push_exp(1, 4'h1, 1'b0, 32'h40, 32'h1111_2222);
    wait_issue(e, ok);
    if (!ok) return;
    accept_cycle(e, 1'b1);
    // accept_cycle returns in the first WAIT_ACK cycle (counter 0).
    for (int i = 0; i <= int'(TMO); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      exp_v = (i == int'(TMO)) ? 2'b10 : 2'b00;
      vectors++;
      if ({req_ack_o, req_error_o, req_rdata_o} !== {exp_v, exp_v, 32'h0}) begin
        miscompares++;
        $display("FAIL timeout_c%0d: got ack=%b err=%b rdata=%h, required ack=%b err=%b rdata=0",
                 i, req_ack_o, req_error_o, req_rdata_o, exp_v, exp_v);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_idle: busy got %b, required 0", busy_o);
    end
    @(negedge clk); core_ack_i = 1'b1; core_error_i = 1'b1; #1;
    vectors++;
    if ({req_ack_o, req_error_o, req_rdata_o} !== '0) begin
      miscompares++;
      $display("FAIL stray_ack: got ack=%b err=%b rdata=%h, required all 0",
               req_ack_o, req_error_o, req_rdata_o);
    end
    @(negedge clk); core_ack_i = 1'b0; core_error_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit ok;
    @(negedge clk);
    set_req(1, 4'h0, 1'b1, 32'h80, 32'h0);
    push_exp(1, 4'h0, 1'b1, 32'h80, 32'h0);
    wait_issue(e, ok);
    if (!ok) return;
    accept_cycle(e, 1'b1);
    @(negedge clk);
    rst_ni = 1'b0; core_ack_i = 1'b1; core_error_i = 1'b1; core_rdata_i = 32'hFFFF_0000; #1;
    vectors++;
    if ({req_accept_o, req_ack_o, req_error_o, req_rdata_o} !== '0) begin
      miscompares++;
      $display("FAIL midreset_out: got acc=%b ack=%b err=%b rdata=%h, required all 0",
               req_accept_o, req_ack_o, req_error_o, req_rdata_o);
    end
    @(negedge clk); rst_ni = 1'b1; #1;
    vectors++;
    if ({busy_o, req_ack_o, req_error_o, req_rdata_o, core_wr_o, core_rd_o, core_addr_o} !== '0) begin
      miscompares++;
      $display("FAIL midreset_after: got busy=%b ack=%b err=%b rdata=%h rd=%b addr=%h, required all 0",
               busy_o, req_ack_o, req_error_o, req_rdata_o, core_rd_o, core_addr_o);
    end
    @(negedge clk);
    core_ack_i = 1'b0; core_error_i = 1'b0; core_rdata_i = 32'hA5A5_5A5A;
    set_req(0, 4'h8, 1'b0, 32'h300, 32'h5555_0000);
    set_req(1, 4'h0, 1'b1, 32'h304, 32'h0);
    push_exp(0, 4'h8, 1'b0, 32'h300, 32'h5555_0000);
    push_exp(1, 4'h0, 1'b1, 32'h304, 32'h0);
    serve(0, 32'h0, 1'b0, 1'b1);
    serve(0, 32'h7777_8888, 1'b0, 1'b1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_ni = 1'b0;
    req_wr = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
    core_accept_i = 1'b0; core_ack_i = 1'b0; core_error_i = 1'b0;
    core_rdata_i = 32'hA5A5_5A5A;
    test_reset;
    test_round_robin;
    test_single_write;
    test_read_routing;
    test_write_precedence;
    test_timeout;
    test_reset_mid;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_left: got %0d entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
